// File: rtl/blink_led_pkg.sv
// Shared types and constants for the multi-channel LED blinker.
// Channel/top state encodings and the reset period length.
package blink_led_pkg;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_ON   = 2'd1,
        CH_OFF  = 2'd2
    } ch_state_e;

    typedef enum logic {
        TOP_IDLE = 1'b0,
        TOP_RUN  = 1'b1
    } top_state_e;

    localparam logic [31:0] DEFAULT_LEN = 32'h004C4B40;

    // Width of a channel index; at least one bit even for a single channel.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/blink_led_multi_if.sv
// Control/status bundle between the blinker and its controller.
// master drives requests and config; slave is the blinker.
interface blink_led_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    import blink_led_pkg::*;

    localparam int CH_W = ch_idx_w(NUM_CH);

    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_on;
    logic [CNT_W-1:0]  cfg_off;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] led_in;
    logic [NUM_CH-1:0] led_we;
    logic              run_req;
    logic              run_stop;
    logic              run_busy;
    logic [NUM_CH-1:0] led_out;

    modport master (
        output cfg_we, cfg_ch, cfg_on, cfg_off,
        output ch_en, led_in, led_we,
        output run_req, run_stop,
        input  run_busy, led_out
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_on, cfg_off,
        input  ch_en, led_in, led_we,
        input  run_req, run_stop,
        output run_busy, led_out
    );

endinterface

// File: rtl/blink_led_channel.sv
// One LED channel: shadow ON/OFF lengths, phase counter, phase FSM.
// The active length is latched at each phase start from the shadows.
module blink_led_channel #(
    parameter int               CNT_W   = 32,
    parameter logic [CNT_W-1:0] RST_LEN = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we_i,
    input  logic [CNT_W-1:0] cfg_on_i,
    input  logic [CNT_W-1:0] cfg_off_i,
    input  logic             start_i,
    input  logic             stop_pend_i,
    input  logic             led_in_i,
    input  logic             led_we_i,
    output logic             led_o,
    output logic             active_d_o
);
    import blink_led_pkg::*;

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] on_q, on_d;
    logic [CNT_W-1:0] off_q, off_d;
    logic             led_q, led_d;
    logic             last;

    // A zero length behaves as a one-cycle phase.
    function automatic logic [CNT_W-1:0] min1(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    assign last       = (cnt_q == len_q - CNT_W'(1));
    assign led_o      = led_q;
    assign active_d_o = (state_d != CH_IDLE);

    // Phase sequencing, manual override and shadow register writes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        led_d   = led_q;
        on_d    = cfg_we_i ? cfg_on_i  : on_q;
        off_d   = cfg_we_i ? cfg_off_i : off_q;
        unique case (state_q)
            CH_IDLE: begin
                if (start_i) begin
                    state_d = CH_ON;
                    cnt_d   = '0;
                    len_d   = min1(on_q);
                    led_d   = 1'b1;
                end else if (led_we_i) begin
                    led_d = led_in_i;
                end
            end
            CH_ON: begin
                if (last) begin
                    state_d = CH_OFF;
                    cnt_d   = '0;
                    len_d   = min1(off_q);
                    led_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CH_OFF: begin
                if (last) begin
                    cnt_d = '0;
                    if (stop_pend_i) begin
                        state_d = CH_IDLE;
                        led_d   = 1'b0;
                    end else begin
                        state_d = CH_ON;
                        len_d   = min1(on_q);
                        led_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = CH_IDLE;
                cnt_d   = '0;
                led_d   = 1'b0;
            end
        endcase
    end

    // Channel state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CH_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            on_q    <= RST_LEN;
            off_q   <= RST_LEN;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            on_q    <= on_d;
            off_q   <= off_d;
            led_q   <= led_d;
        end
    end

endmodule

// File: rtl/blink_led_multi.sv
// Multi-channel LED blinker top: run handshake, stop request, cfg decode.
// Busy tracks the top FSM, which leaves RUN as the last channel goes idle.
module blink_led_multi #(
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = 32,
    parameter logic [31:0] DEFAULT_LEN = blink_led_pkg::DEFAULT_LEN
) (
    input  logic               clk,
    input  logic               reset,
    blink_led_multi_if.slave   bus
);
    import blink_led_pkg::*;

    localparam int CH_W = ch_idx_w(NUM_CH);

    top_state_e        top_q, top_d;
    logic              req_q;
    logic              req_rise;
    logic              start_q, start_d;
    logic              stop_q, stop_d;
    logic [NUM_CH-1:0] run_en_q, run_en_d;
    logic [NUM_CH-1:0] ch_act_d;
    logic [NUM_CH-1:0] ch_led;

    assign req_rise     = bus.run_req & ~req_q;
    assign bus.run_busy = (top_q == TOP_RUN);
    assign bus.led_out  = ch_led;

    // Start on a request edge while idle; finish once no enabled channel runs.
    always_comb begin
        top_d    = top_q;
        run_en_d = run_en_q;
        start_d  = 1'b0;
        stop_d   = stop_q;
        unique case (top_q)
            TOP_IDLE: begin
                if (req_rise && (|bus.ch_en)) begin
                    top_d    = TOP_RUN;
                    run_en_d = bus.ch_en;
                    start_d  = 1'b1;
                end
            end
            TOP_RUN: begin
                if (bus.run_stop) begin
                    stop_d = 1'b1;
                end
                if (~|(ch_act_d & run_en_q)) begin
                    top_d  = TOP_IDLE;
                    stop_d = 1'b0;
                end
            end
        endcase
    end

    // Top FSM, edge detect and stop flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            top_q    <= TOP_IDLE;
            req_q    <= 1'b0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            run_en_q <= '0;
        end else begin
            top_q    <= top_d;
            req_q    <= bus.run_req;
            start_q  <= start_d;
            stop_q   <= stop_d;
            run_en_q <= run_en_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        blink_led_channel #(
            .CNT_W   (CNT_W),
            .RST_LEN (CNT_W'(DEFAULT_LEN))
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .cfg_we_i    (bus.cfg_we && (bus.cfg_ch == CH_W'(i))),
            .cfg_on_i    (bus.cfg_on),
            .cfg_off_i   (bus.cfg_off),
            .start_i     (start_q & run_en_q[i]),
            .stop_pend_i (stop_q),
            .led_in_i    (bus.led_in[i]),
            .led_we_i    (bus.led_we[i]),
            .led_o       (ch_led[i]),
            .active_d_o  (ch_act_d[i])
        );
    end

endmodule

// File: tb/tb_blink_led_multi.sv
// Self-checking bench for blink_led_multi (2 channels, 8-bit lengths).
// Directed scenarios plus randomized runs against a timeline model.
module tb_blink_led_multi;

    localparam int NUM_CH  = 2;
    localparam int CNT_W   = 8;
    localparam int DEF_LEN = 32'h004C4B40 % (1 << CNT_W);

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always #5 clk = ~clk;

    blink_led_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    blink_led_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Model: each running channel holds its remaining phase cycles.
    bit       m_req_prev, m_busy, m_stop;
    bit [1:0] m_run_en, m_pend;
    bit       m_run [2];
    bit       m_on  [2];
    bit       m_led [2];
    int       m_left[2];
    int       sh_on [2];
    int       sh_off[2];

    function automatic int atl1(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic logic [1:0] exp_led();
        return {m_led[1], m_led[0]};
    endfunction

    task automatic model_reset();
        m_req_prev = 0; m_busy = 0; m_stop = 0;
        m_run_en = 0; m_pend = 0;
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_on[i] = 0; m_led[i] = 0; m_left[i] = 0;
            sh_on[i] = DEF_LEN; sh_off[i] = DEF_LEN;
        end
    endtask

    task automatic model_edge();
        bit       rise;
        bit       any_run;
        bit [1:0] pend_next;
        if (reset) begin
            model_reset();
            return;
        end
        rise = bus.run_req && !m_req_prev;
        m_req_prev = bus.run_req;
        for (int i = 0; i < 2; i++) begin
            if (m_pend[i]) begin
                m_run[i] = 1; m_on[i] = 1; m_led[i] = 1;
                m_left[i] = atl1(sh_on[i]);
            end else if (m_run[i]) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    if (m_on[i]) begin
                        m_on[i] = 0; m_led[i] = 0;
                        m_left[i] = atl1(sh_off[i]);
                    end else if (m_stop) begin
                        m_run[i] = 0; m_led[i] = 0;
                    end else begin
                        m_on[i] = 1; m_led[i] = 1;
                        m_left[i] = atl1(sh_on[i]);
                    end
                end
            end else if (bus.led_we[i]) begin
                m_led[i] = bus.led_in[i];
            end
        end
        if (bus.cfg_we) begin
            sh_on[bus.cfg_ch]  = int'(bus.cfg_on);
            sh_off[bus.cfg_ch] = int'(bus.cfg_off);
        end
        pend_next = 0;
        if (!m_busy) begin
            if (rise && bus.ch_en != 0) begin
                m_busy = 1; m_run_en = bus.ch_en; pend_next = bus.ch_en;
            end
        end else begin
            if (bus.run_stop) m_stop = 1;
            any_run = 0;
            for (int i = 0; i < 2; i++)
                if (m_run_en[i] && m_run[i]) any_run = 1;
            if (!any_run) begin
                m_busy = 0; m_stop = 0;
            end
        end
        m_pend = pend_next;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic clear_inputs();
        bus.cfg_we = 0; bus.cfg_ch = 0; bus.cfg_on = 0; bus.cfg_off = 0;
        bus.led_in = 0; bus.led_we = 0;
        bus.run_req = 0; bus.run_stop = 0;
    endtask

    task automatic cfg(input int ch, input int on, input int off);
        bus.cfg_we = 1; bus.cfg_ch = 1'(ch);
        bus.cfg_on = 8'(on); bus.cfg_off = 8'(off);
        tick();
        bus.cfg_we = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        tick();
        tick();
        reset = 0;
        n_tests++;
        if (bus.led_out !== 2'b00 || bus.run_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset led_out=%b busy=%b required 00/0",
                     bus.led_out, bus.run_busy);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            n_tests++;
            if (bus.led_out !== 2'b00 || bus.run_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_hold k=%0d led_out=%b busy=%b required 00/0",
                         k, bus.led_out, bus.run_busy);
            end
        end
    endtask

    task automatic test_blink_cfg_stop();
        int          t;
        logic [13:0] rec;
        logic [13:0] exp_rec;
        logic        e;
        cfg(0, 3, 2);
        bus.ch_en = 2'b01;
        t = cyc;
        bus.run_req = 1;
        tick();
        bus.run_req = 0;
        n_tests++;
        if (bus.run_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_rise busy=%b required 1", bus.run_busy);
        end
        rec = '0;
        for (int k = t + 1; k <= t + 40; k++) begin
            n_tests++;
            if (bus.led_out !== exp_led() || bus.run_busy !== m_busy) begin
                n_fail++;
                $display("FAIL blink_model cyc=%0d led_out=%b busy=%b required %b/%b",
                         k - t, bus.led_out, bus.run_busy, exp_led(), m_busy);
            end
            if (k >= t + 2 && k <= t + 16) begin
                e = ((k - t - 2) % 5) < 3;
                n_tests++;
                if (bus.led_out[0] !== e) begin
                    n_fail++;
                    $display("FAIL blink_pattern t+%0d led0=%b required %b",
                             k - t, bus.led_out[0], e);
                end
            end
            n_tests++;
            if (bus.led_out[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_ch1 t+%0d led1=%b required 0",
                         k - t, bus.led_out[1]);
            end
            if (k >= t + 17 && k <= t + 30) rec[k - t - 17] = bus.led_out[0];
            if (k == t + 35) begin
                n_tests++;
                if (bus.run_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stop_drain busy=%b required 1", bus.run_busy);
                end
            end
            if (k == t + 36) begin
                n_tests++;
                if (bus.run_busy !== 1'b0 || bus.led_out !== 2'b00) begin
                    n_fail++;
                    $display("FAIL stop_done busy=%b led_out=%b required 0/00",
                             bus.run_busy, bus.led_out);
                end
            end
            if (k == t + 40) begin
                n_tests++;
                if (bus.run_busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL no_restart busy=%b required 0", bus.run_busy);
                end
            end
            bus.cfg_we = 0; bus.run_stop = 0; bus.run_req = 0;
            if (k == t + 18) begin
                bus.cfg_we = 1; bus.cfg_ch = 0; bus.cfg_on = 8'd5; bus.cfg_off = 8'd2;
            end
            if (k == t + 31) bus.run_stop = 1;
            if (k == t + 32) bus.run_req = 1;
            tick();
        end
        clear_inputs();
        for (int j = 0; j < 14; j++)
            exp_rec[j] = (j < 3) || (j >= 5 && j < 10) || (j >= 12);
        n_tests++;
        if (rec !== exp_rec) begin
            n_fail++;
            $display("FAIL midphase_cfg led0 trace=%b required %b", rec, exp_rec);
        end
    endtask

    task automatic test_manual();
        bit done;
        bus.led_we = 2'b10; bus.led_in = 2'b10;
        tick();
        bus.led_we = 0; bus.led_in = 0;
        n_tests++;
        if (bus.led_out !== 2'b10) begin
            n_fail++;
            $display("FAIL manual_idle led_out=%b required 10", bus.led_out);
        end
        cfg(1, 4, 4);
        bus.ch_en = 2'b10;
        bus.run_req = 1;
        tick();
        bus.run_req = 0;
        tick();
        bus.led_we = 2'b11; bus.led_in = 2'b01;
        tick();
        bus.led_we = 0; bus.led_in = 0;
        n_tests++;
        if (bus.led_out !== 2'b11) begin
            n_fail++;
            $display("FAIL manual_on led_out=%b required 11", bus.led_out);
        end
        tick();
        tick();
        tick();
        bus.led_we = 2'b10; bus.led_in = 2'b10;
        tick();
        bus.led_we = 0; bus.led_in = 0;
        n_tests++;
        if (bus.led_out !== 2'b01) begin
            n_fail++;
            $display("FAIL manual_off led_out=%b required 01", bus.led_out);
        end
        bus.run_stop = 1;
        tick();
        bus.run_stop = 0;
        done = 0;
        for (int k = 0; k < 50 && !done; k++) begin
            n_tests++;
            if (bus.led_out !== exp_led() || bus.run_busy !== m_busy) begin
                n_fail++;
                $display("FAIL manual_model led_out=%b busy=%b required %b/%b",
                         bus.led_out, bus.run_busy, exp_led(), m_busy);
            end
            if (!bus.run_busy) done = 1;
            else tick();
        end
        n_tests++;
        if (bus.run_busy !== 1'b0 || bus.led_out !== 2'b01) begin
            n_fail++;
            $display("FAIL manual_end busy=%b led_out=%b required 0/01",
                     bus.run_busy, bus.led_out);
        end
    endtask

    task automatic test_fast_reset();
        int  cnt;
        bit  done;
        logic [1:0] e;
        cfg(0, 0, 0);
        cfg(1, 0, 0);
        bus.ch_en = 2'b11;
        bus.run_req = 1;
        tick();
        bus.run_req = 0;
        tick();
        for (int k = 0; k < 8; k++) begin
            e = (k % 2 == 0) ? 2'b11 : 2'b00;
            n_tests++;
            if (bus.led_out !== e || bus.run_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL fast_toggle k=%0d led_out=%b busy=%b required %b/1",
                         k, bus.led_out, bus.run_busy, e);
            end
            tick();
        end
        reset = 1;
        tick();
        reset = 0;
        n_tests++;
        if (bus.led_out !== 2'b00 || bus.run_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset led_out=%b busy=%b required 00/0",
                     bus.led_out, bus.run_busy);
        end
        bus.ch_en = 2'b01;
        bus.run_req = 1;
        tick();
        bus.run_req = 0;
        tick();
        cnt = 0;
        done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            if (!bus.led_out[0]) done = 1;
            else begin
                cnt++;
                tick();
            end
        end
        n_tests++;
        if (cnt != DEF_LEN) begin
            n_fail++;
            $display("FAIL default_len on_cycles=%0d required %0d", cnt, DEF_LEN);
        end
        bus.run_stop = 1;
        tick();
        bus.run_stop = 0;
        done = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            n_tests++;
            if (bus.led_out !== exp_led() || bus.run_busy !== m_busy) begin
                n_fail++;
                $display("FAIL default_model led_out=%b busy=%b required %b/%b",
                         bus.led_out, bus.run_busy, exp_led(), m_busy);
            end
            if (!bus.run_busy) done = 1;
            else tick();
        end
        n_tests++;
        if (bus.run_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL default_stop busy=%b required 0", bus.run_busy);
        end
    endtask

    task automatic test_random();
        int stop_at;
        bit done;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 2; c++)
                cfg(c, $urandom_range(0, 5), $urandom_range(0, 5));
            bus.led_we = 2'($urandom); bus.led_in = 2'($urandom);
            tick();
            bus.led_we = 0;
            bus.ch_en = 2'($urandom);
            bus.run_req = 1;
            bus.run_stop = 1'($urandom_range(0, 1));
            tick();
            bus.run_req = 0; bus.run_stop = 0;
            stop_at = $urandom_range(2, 20);
            done = 0;
            for (int k = 0; k < 300 && !done; k++) begin
                n_tests++;
                if (bus.led_out !== exp_led() || bus.run_busy !== m_busy) begin
                    n_fail++;
                    $display("FAIL random r=%0d k=%0d led_out=%b busy=%b required %b/%b",
                             r, k, bus.led_out, bus.run_busy, exp_led(), m_busy);
                end
                if (k > stop_at && !m_busy) done = 1;
                else begin
                    bus.cfg_we  = ($urandom_range(0, 3) == 0);
                    bus.cfg_ch  = 1'($urandom);
                    bus.cfg_on  = 8'($urandom_range(0, 5));
                    bus.cfg_off = 8'($urandom_range(0, 5));
                    bus.led_we  = 2'($urandom);
                    bus.led_in  = 2'($urandom);
                    bus.run_stop = (k == stop_at) || ($urandom_range(0, 15) == 0);
                    bus.run_req  = ($urandom_range(0, 7) == 0);
                    tick();
                end
            end
            clear_inputs();
            n_tests++;
            if (!done) begin
                n_fail++;
                $display("FAIL random_timeout r=%0d busy=%b required 0", r, bus.run_busy);
            end
        end
    endtask

    initial begin
        reset = 1;
        bus.ch_en = 0;
        clear_inputs();
        model_reset();
        test_reset();
        test_blink_cfg_stop();
        test_manual();
        test_fast_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
